completion_queue: RTL and testbench



---
 rtl/completion_queue.sv | 125 ++++++++++++
 tb/tb_completion_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/completion_queue.sv
// Completion-address FIFO feeding the SPI MISO serializer over its level handshake.
// Entries retire on a clean transfer; aborted transfers are re-offered up to MAX_RETRY times.
`timescale 1ns/1ps
module completion_queue #(
  parameter int ADDRW     = 24,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [ADDRW-1:0]           push_addr,
  output logic                       push_ready,
  output logic                       ser_valid,
  output logic [ADDRW-1:0]           ser_addr,
  input  logic                       ser_ready,
  input  logic                       ser_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop_pulse
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_BUSY
  } state_t;

  logic [ADDRW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [RW-1:0]    r_retry;
  state_t           r_state;
  logic             r_ser_valid;
  logic [ADDRW-1:0] r_ser_addr;
  logic             r_drop_pulse;

  logic w_push;
  logic w_pop;
  logic w_retry_exhausted;

  assign push_ready        = (r_count != CW'(DEPTH));
  assign w_push            = push_valid && push_ready;
  assign w_retry_exhausted = (r_retry == RW'(MAX_RETRY));
  // The head leaves the queue on a clean finish or on an abort with no retries left.
  assign w_pop             = (r_state == S_BUSY) && ser_ready && (!ser_err || w_retry_exhausted);

  assign ser_valid  = r_ser_valid;
  assign ser_addr   = r_ser_addr;
  assign count      = r_count;
  assign drop_pulse = r_drop_pulse;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_retry      <= '0;
      r_state      <= S_IDLE;
      r_ser_valid  <= 1'b0;
      r_ser_addr   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state     <= S_OFFER;
            r_ser_valid <= 1'b1;
            r_ser_addr  <= r_mem[r_rd_ptr];
          end
        end
        S_OFFER: begin
          // Ready already low here (serializer busy for another reason) also counts as a load.
          if (!ser_ready) begin
            r_state     <= S_BUSY;
            r_ser_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          if (ser_ready) begin
            r_state <= S_IDLE;
            if (!ser_err) begin
              r_retry <= '0;
            end else if (w_retry_exhausted) begin
              r_retry      <= '0;
              r_drop_pulse <= 1'b1;
            end else begin
              r_retry <= r_retry + RW'(1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_completion_queue.sv
// Directed bench for completion_queue: handshake, ordering/wrap, retry/drop, concurrent push-pop, reset.
`timescale 1ns/1ps
module tb_completion_queue;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [23:0] push_addr;
  logic        push_ready;
  logic        ser_valid;
  logic [23:0] ser_addr;
  logic        ser_ready;
  logic        ser_err;
  logic [3:0]  count;
  logic        drop_pulse;

  int errors = 0;
  int checks = 0;

  completion_queue #(.ADDRW(24), .DEPTH(8), .MAX_RETRY(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_addr  (push_addr),
    .push_ready (push_ready),
    .ser_valid  (ser_valid),
    .ser_addr   (ser_addr),
    .ser_ready  (ser_ready),
    .ser_err    (ser_err),
    .count      (count),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [23:0] a);
    push_valid = 1'b1;
    push_addr  = a;
    tick();
    push_valid = 1'b0;
  endtask

  // Waits (bounded) for an offer, checks its address, then plays one clean transfer.
  task automatic serve(input logic [23:0] exp_addr);
    int n;
    n = 0;
    while (ser_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ser_valid !== 1'b1) begin
      errors++;
      $display("FAIL serve_timeout: ser_valid=%b required 1 within 20 cycles", ser_valid);
    end
    checks++;
    if (ser_addr !== exp_addr) begin
      errors++;
      $display("FAIL serve_addr: ser_addr=%h required %h", ser_addr, exp_addr);
    end
    ser_ready = 1'b0;
    tick();
    checks++;
    if (ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL serve_busy_valid: ser_valid=%b required 0", ser_valid);
    end
    ser_ready = 1'b1;
    ser_err   = 1'b0;
    tick();
    $display("serve addr=%h count=%0d", exp_addr, count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (count !== 4'd0 || ser_valid !== 1'b0 || ser_addr !== 24'h0 || drop_pulse !== 1'b0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b addr=%h drop=%b pready=%b required 0 0 000000 0 1",
               count, ser_valid, ser_addr, drop_pulse, push_ready);
    end
    rst = 1'b0;
    $display("test_reset count=%0d push_ready=%b", count, push_ready);
  endtask

  task automatic test_offer_hold();
    ser_ready = 1'b1;
    checks++;
    if (push_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_pready: push_ready=%b required 1", push_ready);
    end
    push_one(24'h00ABCD);
    checks++;
    if (count !== 4'd1 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL offer_push: count=%0d valid=%b required 1 0", count, ser_valid);
    end
    tick();
    checks++;
    if (ser_valid !== 1'b1 || ser_addr !== 24'h00ABCD) begin
      errors++;
      $display("FAIL offer_raise: valid=%b addr=%h required 1 00abcd", ser_valid, ser_addr);
    end
    ser_err = 1'b1;  // must be ignored while offering
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ser_valid !== 1'b1 || ser_addr !== 24'h00ABCD || count !== 4'd1) begin
        errors++;
        $display("FAIL offer_stable: cyc=%0d valid=%b addr=%h count=%0d required 1 00abcd 1",
                 i, ser_valid, ser_addr, count);
      end
    end
    ser_err = 1'b0;
    $display("test_offer_hold addr=%h", ser_addr);
  endtask

  task automatic test_complete();
    ser_ready = 1'b0;
    tick();
    checks++;
    if (ser_valid !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL complete_busy: valid=%b count=%0d required 0 1", ser_valid, count);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (ser_valid !== 1'b0 || drop_pulse !== 1'b0) begin
        errors++;
        $display("FAIL complete_wait: cyc=%0d valid=%b drop=%b required 0 0", i, ser_valid, drop_pulse);
      end
    end
    ser_ready = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL complete_pop: count=%0d drop=%b required 0 0", count, drop_pulse);
    end
    tick();
    checks++;
    if (ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL complete_idle: valid=%b required 0", ser_valid);
    end
    $display("test_complete count=%0d", count);
  endtask

  task automatic test_fill_wrap();
    ser_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_one(24'(i));
    end
    checks++;
    if (count !== 4'd8 || push_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d pready=%b required 8 0", count, push_ready);
    end
    push_one(24'h000009);
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL fill_overflow: count=%0d required 8", count);
    end
    // Head 1 was offered and taken while ready was low; finishing it now pops it.
    ser_ready = 1'b1;
    tick();
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL fill_first_pop: count=%0d required 7", count);
    end
    for (int i = 2; i <= 8; i++) begin
      serve(24'(i));
      checks++;
      if (count !== 4'(8 - i)) begin
        errors++;
        $display("FAIL fill_drain: after=%0d count=%0d required %0d", i, count, 8 - i);
      end
    end
    tick();
    tick();
    checks++;
    if (ser_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL fill_empty: valid=%b count=%0d required 0 0", ser_valid, count);
    end
    $display("test_fill_wrap count=%0d", count);
  endtask

  task automatic test_retry_drop();
    ser_ready = 1'b1;
    push_one(24'h123456);
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ser_valid !== 1'b1 || ser_addr !== 24'h123456 || count !== 4'd1) begin
        errors++;
        $display("FAIL retry_offer: try=%0d valid=%b addr=%h count=%0d required 1 123456 1",
                 k, ser_valid, ser_addr, count);
      end
      ser_ready = 1'b0;
      tick();
      ser_ready = 1'b1;
      ser_err   = 1'b1;
      tick();
      ser_err = 1'b0;
      if (k < 3) begin
        checks++;
        if (count !== 4'd1 || drop_pulse !== 1'b0) begin
          errors++;
          $display("FAIL retry_abort: try=%0d count=%0d drop=%b required 1 0", k, count, drop_pulse);
        end
        tick();
      end else begin
        checks++;
        if (count !== 4'd0 || drop_pulse !== 1'b1) begin
          errors++;
          $display("FAIL retry_drop: count=%0d drop=%b required 0 1", count, drop_pulse);
        end
        tick();
        checks++;
        if (drop_pulse !== 1'b0 || ser_valid !== 1'b0) begin
          errors++;
          $display("FAIL retry_drop_end: drop=%b valid=%b required 0 0", drop_pulse, ser_valid);
        end
      end
      $display("test_retry_drop try=%0d count=%0d drop=%b", k, count, drop_pulse);
    end
  endtask

  task automatic test_back_to_back();
    ser_ready = 1'b1;
    push_one(24'h0A0001);
    push_one(24'h0A0002);
    push_one(24'h0A0003);
    checks++;
    if (count !== 4'd3 || ser_addr !== 24'h0A0001) begin
      errors++;
      $display("FAIL b2b_fill: count=%0d addr=%h required 3 0a0001", count, ser_addr);
    end
    ser_ready = 1'b0;
    tick();
    ser_ready  = 1'b1;
    push_valid = 1'b1;
    push_addr  = 24'h0A0004;
    tick();
    push_valid = 1'b0;
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL b2b_count: count=%0d required 3", count);
    end
    tick();
    checks++;
    if (ser_valid !== 1'b1 || ser_addr !== 24'h0A0002) begin
      errors++;
      $display("FAIL b2b_next: valid=%b addr=%h required 1 0a0002", ser_valid, ser_addr);
    end
    serve(24'h0A0002);
    serve(24'h0A0003);
    serve(24'h0A0004);
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_drain: count=%0d required 0", count);
    end
    $display("test_back_to_back count=%0d", count);
  endtask

  task automatic test_reset_busy();
    ser_ready = 1'b1;
    push_one(24'h0B0001);
    push_one(24'h0B0002);
    push_one(24'h0B0003);
    push_one(24'h0B0004);
    ser_ready = 1'b0;
    tick();
    checks++;
    if (count !== 4'd4 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL rbusy_pre: count=%0d valid=%b required 4 0", count, ser_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || ser_valid !== 1'b0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL rbusy_reset: count=%0d valid=%b pready=%b required 0 0 1", count, ser_valid, push_ready);
    end
    ser_ready = 1'b1;
    push_one(24'h0000AA);
    serve(24'h0000AA);
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL rbusy_after: count=%0d required 0", count);
    end
    $display("test_reset_busy count=%0d", count);
  endtask

  initial begin
    rst        = 1'b1;
    push_valid = 1'b0;
    push_addr  = '0;
    ser_ready  = 1'b1;
    ser_err    = 1'b0;
    test_reset();
    test_offer_hold();
    test_complete();
    test_fill_wrap();
    test_retry_drop();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
